// File: rtl/acumulador_bcd.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Define SUBTRACAO_BCD_EN to build ten's-complement subtraction.
module acumulador_bcd #(
  parameter int DIGITOS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*DIGITOS-1:0] a,
  input  logic [4*DIGITOS-1:0] b,
  output logic [4*DIGITOS-1:0] s,
  output logic                 cout,
  output logic                 erro,
  output logic                 busy,
  output logic                 done
);

  localparam int W = 4 * DIGITOS;

  typedef enum logic [1:0] {
    OCIOSO,
    CALC,
    FIM
  } estado_t;

  estado_t        st_q, st_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   s_q, s_d;
  logic           c_q, c_d;
  logic [3:0]     idx_q, idx_d;
  logic           cout_q, cout_d;
  logic           erro_q, erro_d;
  logic           busy_q, done_q;
  logic           sub_in;
  logic           invalido;
  logic [3:0]     ad, bd, bp, dig;
  logic [4:0]     z;
  logic           cnext;

`ifdef SUBTRACAO_BCD_EN
  logic sub_q, sub_d;
  assign sub_in = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_in     = 1'b0;
`endif

  always_comb begin
    invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        invalido = 1'b1;
    end
  end

  // Per-digit rule: binary sum, then +6 when above nine.
  always_comb begin
    ad = a_q[4*idx_q +: 4];
    bd = b_q[4*idx_q +: 4];
`ifdef SUBTRACAO_BCD_EN
    bp = sub_q ? (4'd9 - bd) : bd;
`else
    bp = bd;
`endif
    z = {1'b0, ad} + {1'b0, bp} + {4'd0, c_q};
    if (z > 5'd9) begin
      dig   = z[3:0] + 4'd6;
      cnext = 1'b1;
    end else begin
      dig   = z[3:0];
      cnext = 1'b0;
    end
  end

  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    s_d    = s_q;
    c_d    = c_q;
    idx_d  = idx_q;
    cout_d = cout_q;
    erro_d = erro_q;
`ifdef SUBTRACAO_BCD_EN
    sub_d  = sub_q;
`endif
    unique case (st_q)
      OCIOSO: begin
        if (start) begin
          a_d = a;
          b_d = b;
`ifdef SUBTRACAO_BCD_EN
          sub_d = sub_in;
`endif
          if (invalido) begin
            st_d   = FIM;
            erro_d = 1'b1;
            s_d    = '0;
            cout_d = 1'b0;
          end else begin
            st_d  = CALC;
            idx_d = 4'd0;
            acc_d = '0;
            c_d   = sub_in;
          end
        end
      end
      CALC: begin
        acc_d[4*idx_q +: 4] = dig;
        c_d   = cnext;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(DIGITOS - 1)) begin
          st_d   = FIM;
          s_d    = acc_d;
          cout_d = cnext;
          erro_d = 1'b0;
        end
      end
      FIM:     st_d = OCIOSO;
      default: st_d = OCIOSO;
    endcase
  end

  // busy/done are registered off the state, so they trail it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= OCIOSO;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      s_q    <= '0;
      c_q    <= 1'b0;
      idx_q  <= 4'd0;
      cout_q <= 1'b0;
      erro_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SUBTRACAO_BCD_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      s_q    <= s_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      cout_q <= cout_d;
      erro_q <= erro_d;
      busy_q <= (st_q == CALC);
      done_q <= (st_q == FIM);
`ifdef SUBTRACAO_BCD_EN
      sub_q  <= sub_d;
`endif
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign erro = erro_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_acumulador_bcd.sv
// Directed + random bench for acumulador_bcd (DIGITOS=4),
// scoreboard of expected {s,cout,erro} popped on each done.
module tb_acumulador_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a, b, s;
  logic        cout, erro, busy, done;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int cyc      = 0;

  logic [17:0] sb[$];

  acumulador_bcd #(.DIGITOS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .s    (s),
    .cout (cout),
    .erro (erro),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] aa,
                                        input logic [15:0] bb,
                                        input logic ss);
    int va, vb, r;
    logic bad, e, co;
    logic [3:0] da, db;
    logic [15:0] sv;
    bad = 1'b0;
    va = 0;
    vb = 0;
    for (int i = 3; i >= 0; i--) begin
      da = aa[4*i +: 4];
      db = bb[4*i +: 4];
      if (da > 4'd9 || db > 4'd9) bad = 1'b1;
      va = va * 10 + int'(da);
      vb = vb * 10 + int'(db);
    end
    if (bad) return {16'h0000, 1'b0, 1'b1};
    e = ss;
`ifndef SUBTRACAO_BCD_EN
    e = 1'b0;
`endif
    if (!e) begin
      r  = va + vb;
      co = (r >= 10000);
      r  = r % 10000;
    end else begin
      r  = va - vb;
      co = (r >= 0);
      if (r < 0) r = r + 10000;
    end
    sv = '0;
    for (int i = 0; i < 4; i++) begin
      sv[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {sv, co, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("result", {14'd0, s, cout, erro}, {14'd0, sb.pop_front()});
    end
  end

  task automatic op(input logic [15:0] aa, input logic [15:0] bb,
                    input logic ss, input int lat, input int nbusy);
    int n, nb;
    @(negedge clk);
    a = aa;
    b = bb;
    sub = ss;
    start = 1'b1;
    sb.push_back(model(aa, bb, ss));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    nb = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (busy === 1'b1) nb++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(nb), 32'(nbusy));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1, t2;
    logic [15:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_erro", 32'(erro), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk) rst = 1'b0;

    op(16'h1234, 16'h8766, 1'b0, 5, 4);
    op(16'h5000, 16'h1234, 1'b1, 5, 4);
    op(16'h1234, 16'h5000, 1'b1, 5, 4);
    op(16'h12A4, 16'h0001, 1'b0, 1, 0);
    op(16'h0001, 16'h0001, 1'b0, 5, 4);

    // reset in the second busy cycle
    @(negedge clk);
    a = 16'h4444;
    b = 16'h1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk) rst = 1'b0;
    t0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - t0), 32'd0);
    op(16'h0001, 16'h0002, 1'b0, 5, 4);

    // second start during CALC must be ignored
    @(negedge clk);
    a = 16'h9999;
    b = 16'h0001;
    sub = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'h9999, 16'h0001, 1'b0));
    t0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    chk("one_done", 32'(done_cnt - t0), 32'd1);

    // held start: back-to-back operations
    @(negedge clk);
    a = 16'h0005;
    b = 16'h0007;
    sub = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'h0005, 16'h0007, 1'b0));
    sb.push_back(model(16'h0005, 16'h0007, 1'b0));
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    t1 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    t2 = cyc;
    chk("held_spacing", 32'(t2 - t1), 32'd6);
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      op(ra, rb, 1'($urandom_range(0, 1)), 5, 4);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acumulador_bcd.md
# acumulador_bcd

Parametrised digit-serial BCD adder/subtractor for multi-digit decimal operands. It processes one BCD digit per clock, least-significant first, using the same per-digit rule as the single-digit combinational adder: binary sum, then +6 correction when the sum is above 9. It sits between operand registers and the seven-segment display path and raises a start/busy/done handshake. Subtraction by ten's complement is an optional compiled feature.

## Interface
- DIGITOS, default 4: number of BCD digits per operand; legal range 1..8.
- clk  in  1  system clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request an operation; sampled only in state OCIOSO.
- sub  in  1  0 = a+b, 1 = a−b. Ignored (treated as 0) unless SUBTRACAO_BCD_EN is defined.
- a  in  4*DIGITOS  operand A, packed BCD; digit 0 is in bits [3:0].
- b  in  4*DIGITOS  operand B, packed BCD.
- s  out  4*DIGITOS  result, packed BCD; registered.
- cout  out  1  decimal carry out of the top digit; registered.
- erro  out  1  an operand digit was invalid (>9); registered.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when s, cout and erro are valid.

## Operation
- FSM states are OCIOSO, CALC and FIM. The reset state is OCIOSO.
- Reset values: s=0, cout=0, erro=0, busy=0, done=0. The internal operand, shift and carry registers and the digit index all reset to 0.
- **OCIOSO with start=1:**
  - Latch a, b and sub (sub is forced to 0 when the macro is absent).
  - Check every digit of a and b. If any digit is greater than 9, go to FIM with erro_next=1, s_next=0 and cout_next=0.
  - Otherwise go to CALC with index=0 and erro_next=0. The initial carry is 0 for addition and 1 for subtraction.
- **OCIOSO with start=0:** remain in OCIOSO. All outputs hold.
- **CALC, digit i:**
  - Compute b'_i = b_i when adding, or 9−b_i when subtracting.
  - Compute z = a_i + b'_i + c. The value of z is at most 19 and fits in 5 bits.
  - If z > 9: the digit is z+6 taken mod 16, and the next carry is 1. Otherwise the digit is z and the next carry is 0.
  - Store the digit in internal slot i and increment the index.
  - After digit DIGITOS−1, go to FIM with s_next = internal result and cout_next = final carry.
- **FIM:**
  - s, cout and erro take their next values on entry to FIM.
  - done=1 for exactly this one cycle, then return to OCIOSO unconditionally.
- **Subtraction result:**
  - cout=1 means a ≥ b, and s = a−b.
  - cout=0 means a < b, and s = 10^DIGITOS − (b−a), i.e. the ten's complement; the sign is carried only by cout.
- **start while busy or in FIM:** ignored and not queued. The latched operands do not change mid-operation.
- **Output stability:** s, cout and erro change only on entry to FIM (or on reset). They hold their values until the next completed operation.
- **Reset mid-operation:** the FSM returns to OCIOSO immediately and the reset values above apply. The aborted operation produces no done pulse.

## Timing
- Let start be sampled high in OCIOSO at edge k. Then:
  - busy=1 during the cycles following edges k+1 through k+DIGITOS.
  - done=1 during the cycle following edge k+DIGITOS+1, with results valid in that same cycle.
- Invalid operand: busy stays 0, and done=1 in the cycle following edge k+1.
- Minimum start-to-start spacing is DIGITOS+2 cycles. A start held high continuously launches a new operation on the first OCIOSO cycle after done.
- There is no combinational path from any input to any output.

## Configuration
- **SUBTRACAO_BCD_EN defined:** the sub input is latched. The nines-complement mux on b and the carry-in of 1 are built.
- **SUBTRACAO_BCD_EN not defined:** the sub port is present but unused. The block is addition-only and has no complement logic.
- The handshake, latency and reset behaviour are identical in both builds.

## Test plan
All scenarios use DIGITOS=4.
- **Addition with full ripple:** a=0x1234, b=0x8766, sub=0 → s=0x0000, cout=1, erro=0. done appears exactly 5 cycles after the sampled start edge, and busy is high for 4 cycles.
- **Subtraction:** with SUBTRACAO_BCD_EN defined:
  - a=0x5000, b=0x1234, sub=1 → s=0x3766, cout=1.
  - a=0x1234, b=0x5000, sub=1 → s=0x6234, cout=0.
  - Without the macro, the first pair with sub=1 → s=0x6234, cout=0, i.e. the addition result.
- **Invalid digit:** a=0x12A4, b=0x0001, start → busy never rises, done arrives 1 cycle after start, erro=1, s=0x0000, cout=0. A following valid operation 0x0001+0x0001 gives erro=0 and s=0x0002.
- **Start ignored while busy:** start 0x9999+0x0001, pulse start again with different operands during CALC → exactly one done, with s=0x0000 and cout=1. A held start produces back-to-back operations spaced 6 cycles apart.
- **Reset mid-operation:** assert rst in the second CALC cycle → busy=0, done=0, s=0x0000 and the FSM in OCIOSO immediately. No done pulse follows, and the next start runs normally.
- **Random check:** random valid BCD operands in both modes, checked against a decimal reference model of s and cout, with no operand change while busy.
